bus_resp: RTL and testbench

Memory-side responder for the 65C02 core: consumes the CPU's address bus (ABH:ABL), write enable and write data, and supplies read data on DB plus the RDY stall signal. Decodes one configurable I/O page to a req/ack peripheral port with wait-state insertion; all other addresses go to a zero-wait synchronous RAM. Sits between the CPU top level and the memory/peripheral fabric.

---
 rtl/bus_resp_pkg.sv | 7 +
 rtl/bus_resp_timer.sv | 18 +
 rtl/bus_resp.sv | 96 +++++++++
 tb/tb_bus_resp.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bus_resp_pkg.sv
// bus_resp_pkg: shared types and constants for the 65C02 bus responder.
package bus_resp_pkg;
  typedef enum logic {IDLE, IO_WAIT} state_t;
  typedef enum logic {SRC_RAM, SRC_IO} src_t;
  localparam logic [7:0] IO_ABORT_DATA = 8'hFF;
  localparam logic [7:0] DEF_IO_PAGE = 8'hFE;
endpackage

// File: rtl/bus_resp_timer.sv
// bus_resp_timer: counts I/O wait cycles and pulses o_expire in the MAX-th enabled cycle.
module bus_resp_timer #(
  parameter int unsigned MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 8'd1;
  // r_cnt holds the number of wait cycles already completed
  assign o_expire = i_en && (r_cnt == 8'(MAX - 1));
endmodule

// File: rtl/bus_resp.sv
// bus_resp: 65C02 memory-side responder; zero-wait RAM plus one req/ack I/O page.
// Define BUS_RESP_TIMEOUT_EN to build the I/O timeout/abort path and io_err.
module bus_resp
  import bus_resp_pkg::*;
#(
  parameter logic [7:0]  IO_PAGE    = DEF_IO_PAGE,
  parameter int unsigned IO_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic [7:0]  DB,
  output logic        RDY,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  output logic        io_err,
  input  logic        err_clr
);
  state_t     r_state;
  src_t       r_src;
  logic [7:0] r_io_data;
  logic       r_boot;
  logic       w_io_hit;
  logic       w_expire;
  assign RDY       = (r_state == IDLE);
  assign w_io_hit  = RDY && (AB[15:8] == IO_PAGE);
  assign ram_addr  = AB;
  assign ram_wdata = DO;
  assign ram_we    = WE && RDY && !w_io_hit;
  // r_boot forces DB to zero until the first address cycle after reset
  assign DB = r_boot ? 8'h00 : (r_src == SRC_RAM) ? ram_rdata : r_io_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_src     <= SRC_RAM;
      r_io_data <= '0;
      r_boot    <= 1'b1;
      io_req    <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
    end else begin
      r_boot <= 1'b0;
      if (r_state == IDLE) begin
        if (w_io_hit) begin
          io_req   <= 1'b1;
          io_we    <= WE;
          io_addr  <= AB[7:0];
          io_wdata <= DO;
          r_state  <= IO_WAIT;
        end else r_src <= SRC_RAM;
      end else if (io_ack) begin
        io_req  <= 1'b0;
        if (!io_we) r_io_data <= io_rdata;
        r_src   <= SRC_IO;
        r_state <= IDLE;
      end else if (w_expire) begin
        io_req    <= 1'b0;
        r_io_data <= IO_ABORT_DATA;
        r_src     <= SRC_IO;
        r_state   <= IDLE;
      end
    end
`ifdef BUS_RESP_TIMEOUT_EN
  logic r_io_err;
  logic w_abort;
  bus_resp_timer #(.MAX(IO_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state == IDLE),
    .i_en     (r_state == IO_WAIT),
    .o_expire (w_expire)
  );
  // a late ack still wins over the expiring counter
  assign w_abort = (r_state == IO_WAIT) && !io_ack && w_expire;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_io_err <= 1'b0;
    else r_io_err <= w_abort || (r_io_err && !err_clr);
  assign io_err = r_io_err;
`else
  logic w_unused;
  assign w_expire = 1'b0;
  assign w_unused = err_clr;
  assign io_err   = 1'b0;
`endif
endmodule

// File: tb/tb_bus_resp.sv
// tb_bus_resp: directed bench for bus_resp with a transaction-level expectation model.
module tb_bus_resp;
  localparam int T = 4;
`ifdef BUS_RESP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] AB, ram_addr;
  logic WE, RDY, ram_we, io_req, io_we, io_ack, io_err, err_clr;
  logic [7:0] DO, DB, ram_wdata, ram_rdata, io_addr, io_wdata, io_rdata;
  int checks = 0, errors = 0;
  logic exp_rdy = 1, exp_req = 0, exp_ramwe = 0, exp_err = 0, exp_iowe = 0;
  logic chk_db = 1, chk_io = 1;
  logic [7:0] exp_db = 0, exp_ioaddr = 0, exp_iowdata = 0;
  logic pend_chk = 0, pend_err = 0;
  logic [7:0] pend_db = 0, pend_ram = 0, m_io_data = 0;
  bit m_known = 0;

  bus_resp #(.IO_PAGE(8'hFE), .IO_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .AB(AB), .WE(WE), .DO(DO), .DB(DB), .RDY(RDY),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack), .io_err(io_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("RDY", 16'(RDY), 16'(exp_rdy));
    chk("io_req", 16'(io_req), 16'(exp_req));
    chk("ram_we", 16'(ram_we), 16'(exp_ramwe));
    chk("io_err", 16'(io_err), 16'(exp_err));
    chk("ram_addr", ram_addr, AB);
    chk("ram_wdata", 16'(ram_wdata), 16'(DO));
    if (chk_db) chk("DB", 16'(DB), 16'(exp_db));
    if (chk_io) begin
      chk("io_we", 16'(io_we), 16'(exp_iowe));
      chk("io_addr", 16'(io_addr), 16'(exp_ioaddr));
      chk("io_wdata", 16'(io_wdata), 16'(exp_iowdata));
    end
  end

  task automatic step();
    @(posedge clk); #1;
    chk_db = pend_chk; exp_db = pend_db; ram_rdata = pend_ram; exp_err = pend_err;
    pend_chk = 0; io_ack = 0; err_clr = 0; chk_io = 0;
  endtask

  task automatic ram_access(input logic [15:0] a, input logic we, input logic [7:0] d,
                            input logic [7:0] rd, input logic ack, input logic clr);
    step();
    AB = a; WE = we; DO = d; io_ack = ack; err_clr = clr;
    exp_rdy = 1; exp_req = 0; exp_ramwe = we;
    pend_chk = !we; pend_db = rd; pend_ram = rd;
    if (clr) pend_err = 0;
  endtask

  // ack_at: wait cycle carrying io_ack (1 = first); 0 = never (timeout builds only)
  task automatic io_access(input logic [15:0] a, input logic we, input logic [7:0] d,
                           input logic [7:0] rd, input int ack_at);
    bit abort;
    int waits;
    abort = TO_EN && (ack_at == 0 || ack_at > T);
    waits = abort ? T : ack_at;
    step();
    AB = a; WE = we; DO = d;
    exp_rdy = 1; exp_req = 0; exp_ramwe = 0;
    for (int k = 1; k <= waits; k++) begin
      step();
      AB = 16'h0000; WE = 1; DO = 8'hEE;
      exp_rdy = 0; exp_req = 1; exp_ramwe = 0;
      chk_io = 1; exp_iowe = we; exp_ioaddr = a[7:0]; exp_iowdata = d;
      if (k == ack_at) begin io_ack = 1; io_rdata = rd; end
    end
    if (abort) begin m_io_data = 8'hFF; m_known = 1; pend_err = 1; end
    else if (!we) begin m_io_data = rd; m_known = 1; end
    pend_chk = m_known; pend_db = m_io_data;
  endtask

  initial begin
    AB = 0; WE = 0; DO = 0; ram_rdata = 8'h3C; io_rdata = 0; io_ack = 0; err_clr = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    ram_access(16'h1234, 0, 8'h00, 8'h5A, 0, 0);
    ram_access(16'h2000, 0, 8'h00, 8'h11, 0, 0);
    #3 chk("lit_ram_db", 16'(DB), 16'h005A);
    chk("lit_ram_noreq", 16'(io_req), 16'h0000);
    ram_access(16'h4000, 1, 8'h55, 8'h00, 1, 0);
    io_access(16'hFE20, 0, 8'h00, 8'h77, 1);
    ram_access(16'h0300, 0, 8'h00, 8'h81, 0, 0);
    #3 chk("lit_io_db", 16'(DB), 16'h0077);
    io_access(16'hFE30, 0, 8'h00, 8'h5C, 1);
    io_access(16'hFE31, 0, 8'h00, 8'h6D, 2);
    io_access(16'hFE10, 1, 8'hC3, 8'h99, 3);
    ram_access(16'h0400, 0, 8'h00, 8'h24, 0, 0);
    #3 chk("lit_wr_db", 16'(DB), 16'h006D);
    chk("lit_io_addr", 16'(io_addr), 16'h0010);
    chk("lit_io_wdata", 16'(io_wdata), 16'h00C3);
    chk("lit_io_we", 16'(io_we), 16'h0001);
`ifdef BUS_RESP_TIMEOUT_EN
    io_access(16'hFE40, 0, 8'h00, 8'h12, 0);
    ram_access(16'h0500, 0, 8'h00, 8'h66, 0, 0);
    #3 chk("lit_abort_db", 16'(DB), 16'h00FF);
    chk("lit_abort_err", 16'(io_err), 16'h0001);
    ram_access(16'h0501, 0, 8'h00, 8'h67, 0, 1);
    ram_access(16'h0502, 0, 8'h00, 8'h68, 0, 0);
    io_access(16'hFE41, 0, 8'h00, 8'h34, T);
    ram_access(16'h0503, 0, 8'h00, 8'h69, 0, 0);
    #3 chk("lit_late_ack_db", 16'(DB), 16'h0034);
    chk("lit_late_ack_err", 16'(io_err), 16'h0000);
`endif
    step();
    AB = 16'hFE50; WE = 0; DO = 8'h00;
    exp_rdy = 1; exp_req = 0; exp_ramwe = 0;
    step();
    AB = 16'h0000; WE = 0;
    exp_rdy = 0; exp_req = 1; exp_ramwe = 0;
    chk_io = 1; exp_iowe = 0; exp_ioaddr = 8'h50; exp_iowdata = 8'h00;
    #6 ram_rdata = 8'hA5; rst_n = 0;
    exp_rdy = 1; exp_req = 0; chk_db = 1; exp_db = 0; exp_err = 0;
    exp_iowe = 0; exp_ioaddr = 0; exp_iowdata = 0;
    pend_err = 0; pend_chk = 0; m_known = 0; m_io_data = 0;
    #1 chk("lit_rst_req", 16'(io_req), 16'h0000);
    chk("lit_rst_rdy", 16'(RDY), 16'h0001);
    chk("lit_rst_db", 16'(DB), 16'h0000);
    @(posedge clk); #4 rst_n = 1;
    ram_access(16'h0000, 0, 8'h00, 8'h9B, 0, 0);
    ram_access(16'h0001, 0, 8'h00, 8'h00, 0, 0);
    #3 chk("lit_post_rst_db", 16'(DB), 16'h009B);
    chk("lit_post_rst_rdy", 16'(RDY), 16'h0001);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
